pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have parameter DIV_TIMEOUT, default 40, meaning the maximum DIV_WAIT cycles before forced abort.
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset: asynchronous, active-low (asserted at 0).
REQ-004 The block SHALL have port id_load_use_i, input, 1, decode reports that a source operand is the destination of the load now in EX.
REQ-005 The block SHALL have port ex_div_req_i, input, 1, EX holds a divide that needs the multi-cycle divider.
REQ-006 The block SHALL have port div_done_i, input, 1, the divider's result is valid this cycle.
REQ-007 The block SHALL have port excp_req_i, input, 1, MEM requests a pipeline flush (exception or eret).
REQ-008 The block SHALL have port excp_pc_i, input, 32, the redirect address, valid with excp_req_i.
REQ-009 The block SHALL have port stall_o, output, 6, per-stage hold: bit0 pc, bit1 if/id, bit2 id, bit3 ex, bit4 mem, bit5 wb.
REQ-010 The block SHALL have port flush_o, output, 1, clear all pipeline registers this cycle.
REQ-011 The block SHALL have port new_pc_o, output, 32, redirect address, valid while flush_o=1.
REQ-012 The block SHALL have port div_start_o, output, 1, one-cycle start pulse to the divider.
REQ-013 The block SHALL have port div_cancel_o, output, 1, one-cycle abort pulse to the divider.
REQ-014 The block SHALL have port div_timeout_o, output, 1, sticky flag: a divide hit DIV_TIMEOUT.
REQ-015 The block SHALL have port stall_cnt_o, output, 32, saturating count of cycles with stall_o != 0.

Function
REQ-016 The block SHALL have three registered states: RUN, DIV_WAIT and FLUSH.
REQ-017 Priority per cycle SHALL be excp_req_i, then divide, then load-use.
REQ-018 In RUN with excp_req_i=1, the block SHALL register excp_pc_i and enter FLUSH.
REQ-019 In FLUSH, the block SHALL drive flush_o=1, new_pc_o=the registered address and stall_o=000000 for exactly one cycle, then return to RUN.
REQ-020 In RUN with ex_div_req_i=1 and no excp_req_i, the block SHALL pulse div_start_o in that cycle, drive stall_o=001111 in the same cycle (Mealy), clear the cycle counter and enter DIV_WAIT.
REQ-021 In DIV_WAIT, stall_o SHALL be 001111 and the counter SHALL increment each cycle.
REQ-022 In DIV_WAIT with div_done_i=1, stall_o SHALL be 000000 in that cycle and the state SHALL return to RUN, so EX captures the result.
REQ-023 In DIV_WAIT with counter = DIV_TIMEOUT-1 and no div_done_i, the block SHALL pulse div_cancel_o, set div_timeout_o, drive stall_o=000000 and return to RUN.
REQ-024 In DIV_WAIT with excp_req_i=1, the block SHALL pulse div_cancel_o, register excp_pc_i and enter FLUSH; excp_req_i SHALL win over a simultaneous div_done_i.
REQ-025 In RUN with id_load_use_i=1 and no higher-priority request, stall_o SHALL be 000111 combinationally, inserting one EX bubble; no state change is required.
REQ-026 Otherwise in RUN, stall_o SHALL be 000000, and flush_o, div_start_o and div_cancel_o SHALL be 0.
REQ-027 stall_cnt_o SHALL increment on every cycle with stall_o != 0 and SHALL saturate at 32'hFFFFFFFF.
REQ-028 div_done_i outside DIV_WAIT SHALL be ignored.

Reset
REQ-029 While rst=0, the block SHALL be in state RUN with counter=0, registered new_pc=0, div_timeout_o=0 and stall_cnt_o=0, and all outputs 0.
REQ-030 A reset asserted during DIV_WAIT or FLUSH SHALL abort it with no div_cancel_o pulse; the divider is reset by the same rst.

Structure
REQ-031 The state encodings, the stall vector constants (000000, 000111, 001111) and the DivTimeout default SHALL live in the shared defines package.
REQ-032 The block SHALL be a single module with no sub-modules; the FSM, counter and performance counter each SHALL be a separate process.

Verification
REQ-033 The bench SHALL check: id_load_use_i=1 for one cycle in RUN -> stall_o=000111 that cycle, then 000000; stall_cnt_o=1.
REQ-034 The bench SHALL check: ex_div_req_i=1, then div_done_i on the 10th DIV_WAIT cycle -> div_start_o one pulse, stall_o=001111 for 10 cycles, then 000000 in the done cycle.
REQ-035 The bench SHALL check: a divide with no div_done_i, DIV_TIMEOUT=40 -> div_cancel_o pulses on the 40th DIV_WAIT cycle, div_timeout_o=1 stays set, state=RUN.
REQ-036 The bench SHALL check: excp_req_i=1 with excp_pc_i=32'h0000_0020 in the same cycle as div_done_i in DIV_WAIT -> div_cancel_o=1, next cycle flush_o=1 and new_pc_o=32'h0000_0020.
REQ-037 The bench SHALL check: excp_req_i and id_load_use_i asserted together in RUN -> stall_o=000000, FLUSH the next cycle.
REQ-038 The bench SHALL check: rst=0 asynchronously mid DIV_WAIT -> all outputs 0 immediately, no div_cancel_o pulse, state RUN after release.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encodings, stall vectors and divide timeout default for pipe_ctrl.
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, DIV_WAIT = 2'd1, FLUSH = 2'd2} state_t;
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_LU = 6'b000111;
  localparam logic [5:0] STALL_DIV = 6'b001111;
  localparam int DIV_TIMEOUT_DEF = 40;
endpackage

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard controller for load-use stalls, multi-cycle divide waits and exception flushes.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_TIMEOUT = DIV_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_load_use_i,
  input  logic        ex_div_req_i,
  input  logic        div_done_i,
  input  logic        excp_req_i,
  input  logic [31:0] excp_pc_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        div_start_o,
  output logic        div_cancel_o,
  output logic        div_timeout_o,
  output logic [31:0] stall_cnt_o
);
  localparam int CW = $clog2(DIV_TIMEOUT + 1);
  state_t st, nxt;
  logic [CW-1:0] cnt;
  logic [31:0] pc_q;
  logic [5:0] stall;
  logic flush, start, cancel, take_pc, set_to;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= RUN;
      pc_q <= '0;
      div_timeout_o <= 1'b0;
    end else begin
      st <= nxt;
      if (take_pc) pc_q <= excp_pc_i;
      if (set_to) div_timeout_o <= 1'b1;
    end
  end
  always_comb begin
    nxt = st;
    stall = STALL_NONE;
    flush = 1'b0;
    start = 1'b0;
    cancel = 1'b0;
    take_pc = 1'b0;
    set_to = 1'b0;
    case (st)
      RUN: begin
        if (excp_req_i) begin
          take_pc = 1'b1;
          nxt = FLUSH;
        end else if (ex_div_req_i) begin
          start = 1'b1;
          stall = STALL_DIV;
          nxt = DIV_WAIT;
        end else if (id_load_use_i) stall = STALL_LU;
      end
      DIV_WAIT: begin
        if (excp_req_i) begin
          cancel = 1'b1;
          take_pc = 1'b1;
          nxt = FLUSH;
        end else if (div_done_i) nxt = RUN;
        else if (cnt == CW'(DIV_TIMEOUT - 1)) begin
          cancel = 1'b1;
          set_to = 1'b1;
          nxt = RUN;
        end else stall = STALL_DIV;
      end
      FLUSH: begin
        flush = 1'b1;
        nxt = RUN;
      end
      default: nxt = RUN;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= '0;
    else if (start) cnt <= '0;
    else if (st == DIV_WAIT) cnt <= cnt + 1'b1;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt_o <= '0;
    else if (stall_o != STALL_NONE && stall_cnt_o != 32'hFFFF_FFFF) stall_cnt_o <= stall_cnt_o + 1'b1;
  end
  // Reset forces every combinational output low so nothing leaks out while rst is held.
  assign stall_o = rst ? stall : STALL_NONE;
  assign flush_o = rst & flush;
  assign new_pc_o = (rst & flush) ? pc_q : '0;
  assign div_start_o = rst & start;
  assign div_cancel_o = rst & cancel;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed checks of pipe_ctrl stalls, divide handshake, timeout, flush and reset.
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic id_load_use_i = 1'b0;
  logic ex_div_req_i = 1'b0;
  logic div_done_i = 1'b0;
  logic excp_req_i = 1'b0;
  logic [31:0] excp_pc_i = '0;
  logic [5:0] stall_o;
  logic flush_o;
  logic [31:0] new_pc_o;
  logic div_start_o;
  logic div_cancel_o;
  logic div_timeout_o;
  logic [31:0] stall_cnt_o;
  int total = 0;
  int bad = 0;
  int starts;

  pipe_ctrl #(.DIV_TIMEOUT(40)) dut (
    .clk(clk), .rst(rst), .id_load_use_i(id_load_use_i), .ex_div_req_i(ex_div_req_i),
    .div_done_i(div_done_i), .excp_req_i(excp_req_i), .excp_pc_i(excp_pc_i),
    .stall_o(stall_o), .flush_o(flush_o), .new_pc_o(new_pc_o), .div_start_o(div_start_o),
    .div_cancel_o(div_cancel_o), .div_timeout_o(div_timeout_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_stall"}, {26'd0, stall_o}, 32'd0);
    chk({tag, "_flush"}, {31'd0, flush_o}, 32'd0);
    chk({tag, "_newpc"}, new_pc_o, 32'd0);
    chk({tag, "_start"}, {31'd0, div_start_o}, 32'd0);
    chk({tag, "_cancel"}, {31'd0, div_cancel_o}, 32'd0);
  endtask

  initial begin
    #2;
    chk_idle("rst");
    chk("rst_to", {31'd0, div_timeout_o}, 32'd0);
    chk("rst_cnt", stall_cnt_o, 32'd0);
    step();
    rst = 1'b1;
    // load-use bubble
    step(); id_load_use_i = 1'b1; #1;
    chk("lu_stall", {26'd0, stall_o}, 32'h07);
    step(); id_load_use_i = 1'b0; #1;
    chk("lu_after", {26'd0, stall_o}, 32'h00);
    chk("lu_cnt", stall_cnt_o, 32'd1);
    // divide completing on the 10th wait cycle
    starts = 0;
    step(); ex_div_req_i = 1'b1; #1;
    chk("div_start", {31'd0, div_start_o}, 32'd1);
    chk("div_st0", {26'd0, stall_o}, 32'h0F);
    starts += int'(div_start_o);
    step(); ex_div_req_i = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      #1;
      chk($sformatf("div_w%0d", i), {26'd0, stall_o}, 32'h0F);
      starts += int'(div_start_o);
      step();
    end
    div_done_i = 1'b1; #1;
    chk("div_done_stall", {26'd0, stall_o}, 32'h00);
    chk("div_done_cancel", {31'd0, div_cancel_o}, 32'd0);
    starts += int'(div_start_o);
    step(); div_done_i = 1'b0; #1;
    chk("div_run_stall", {26'd0, stall_o}, 32'h00);
    chk("div_starts", starts, 32'd1);
    chk("div_cnt", stall_cnt_o, 32'd11);
    // divide timing out
    step(); ex_div_req_i = 1'b1; #1;
    chk("to_start", {31'd0, div_start_o}, 32'd1);
    step(); ex_div_req_i = 1'b0;
    for (int i = 1; i <= 39; i++) begin
      #1;
      chk($sformatf("to_w%0d_cancel", i), {31'd0, div_cancel_o}, 32'd0);
      chk($sformatf("to_w%0d_stall", i), {26'd0, stall_o}, 32'h0F);
      step();
    end
    #1;
    chk("to_cancel", {31'd0, div_cancel_o}, 32'd1);
    chk("to_stall40", {26'd0, stall_o}, 32'h00);
    chk("to_flag_pre", {31'd0, div_timeout_o}, 32'd0);
    step(); #1;
    chk("to_flag", {31'd0, div_timeout_o}, 32'd1);
    chk_idle("to_run");
    chk("to_cnt", stall_cnt_o, 32'd51);
    step(); id_load_use_i = 1'b1; #1;
    chk("to_run_lu", {26'd0, stall_o}, 32'h07);
    step(); id_load_use_i = 1'b0; #1;
    chk("to_flag_sticky", {31'd0, div_timeout_o}, 32'd1);
    // exception beats a simultaneous div_done
    step(); ex_div_req_i = 1'b1;
    step(); ex_div_req_i = 1'b0;
    step(); step(); step();
    excp_req_i = 1'b1; excp_pc_i = 32'h0000_0020; div_done_i = 1'b1; #1;
    chk("ex_cancel", {31'd0, div_cancel_o}, 32'd1);
    chk("ex_stall", {26'd0, stall_o}, 32'h00);
    chk("ex_noflush", {31'd0, flush_o}, 32'd0);
    step(); excp_req_i = 1'b0; excp_pc_i = '0; div_done_i = 1'b0; #1;
    chk("ex_flush", {31'd0, flush_o}, 32'd1);
    chk("ex_pc", new_pc_o, 32'h0000_0020);
    chk("ex_fl_stall", {26'd0, stall_o}, 32'h00);
    step(); #1;
    chk_idle("ex_after");
    chk("ex_cnt", stall_cnt_o, 32'd56);
    // exception wins over load-use in RUN
    step(); excp_req_i = 1'b1; excp_pc_i = 32'h0000_0100; id_load_use_i = 1'b1; #1;
    chk("exlu_stall", {26'd0, stall_o}, 32'h00);
    step(); excp_req_i = 1'b0; excp_pc_i = '0; id_load_use_i = 1'b0; #1;
    chk("exlu_flush", {31'd0, flush_o}, 32'd1);
    chk("exlu_pc", new_pc_o, 32'h0000_0100);
    chk("exlu_cnt", stall_cnt_o, 32'd56);
    // div_done outside DIV_WAIT is ignored
    step(); div_done_i = 1'b1; #1;
    chk_idle("done_run");
    step(); div_done_i = 1'b0; id_load_use_i = 1'b1; #1;
    chk("done_run_lu", {26'd0, stall_o}, 32'h07);
    step(); id_load_use_i = 1'b0;
    // asynchronous reset in the middle of a divide
    step(); ex_div_req_i = 1'b1;
    step(); ex_div_req_i = 1'b0;
    step(); #1;
    chk("ar_pre_stall", {26'd0, stall_o}, 32'h0F);
    #1 rst = 1'b0; #1;
    chk_idle("ar_now");
    chk("ar_to", {31'd0, div_timeout_o}, 32'd0);
    chk("ar_cnt", stall_cnt_o, 32'd0);
    step(); #1;
    chk("ar_hold_cancel", {31'd0, div_cancel_o}, 32'd0);
    rst = 1'b1; #1;
    chk_idle("ar_rel");
    step(); #1;
    chk_idle("ar_run");
    id_load_use_i = 1'b1; #1;
    chk("ar_run_lu", {26'd0, stall_o}, 32'h07);
    step(); id_load_use_i = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
